// File: rtl/key_seq_mealy.sv
// key_seq_mealy: turns debounced key presses into a serial bit stream and runs
// an overlapping Mealy detector for a 4-bit PATTERN on it.
//   key[0] press -> bit 0, key[1] press -> bit 1 (keys are active-low).
// Outputs: one-cycle bit_valid/bit_val, Mealy detect pulse, wrapping detection
// counter and the matched-prefix length on state.
// Optional build macro DET_REG_EN: register detect (one cycle later, glitch-free).
module key_seq_mealy #(
   parameter logic [3:0] PATTERN = 4'b1101,
   parameter int         CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       debkey,
   output logic             bit_valid,
   output logic             bit_val,
   output logic             detect,
   output logic [CNT_W-1:0] det_count,
   output logic [2:0]       state
);

   // Next matched-prefix length after seeing bit b in state k: the longest
   // suffix of (PATTERN prefix of length k, then b) that is itself a prefix of
   // PATTERN, limited to 3 so a full match falls back to the overlap length.
   function automatic logic [1:0] calc_next(input logic [1:0] k, input logic b);
      int         seq_i;
      int         len_i;
      logic [1:0] res;
      len_i = int'(k) + 32'sd1;
      seq_i = ((int'(PATTERN) >> (32'sd4 - int'(k))) << 32'sd1) | int'(b);
      res   = 2'd0;
      for (int j = 1; j <= 3; j++) begin
         if ((j <= len_i) &&
             (((seq_i ^ (int'(PATTERN) >> (32'sd4 - j))) & ((32'sd1 << j) - 32'sd1)) == 32'sd0)) begin
            res = 2'(j);
         end
      end
      return res;
   endfunction

   logic [1:0]       sync1_r;
   logic [1:0]       sync2_r;
   logic [1:0]       prev_r;
   logic [1:0]       press_s;
   logic             bit_valid_s;
   logic             bit_val_s;
   logic             detect_s;
   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic [1:0]       next_tbl_s [8];

   // Transition table indexed by {state, bit}, elaborated from PATTERN.
   for (genvar g = 0; g < 8; g++) begin : g_next_tbl
      assign next_tbl_s[g] = calc_next(2'(g / 2), 1'(g % 2));
   end

   // Key synchroniser and previous-level register; idle (released) after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 2'b11;
         sync2_r <= 2'b11;
         prev_r  <= 2'b11;
      end else begin
         sync1_r <= debkey;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Detector state and detection counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= 2'd0;
         count_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         count_r <= count_nxt_s;
      end
   end

   // Next-state logic: advance only on an accepted bit; count each match.
   always_comb begin
      state_nxt_s = state_r;
      count_nxt_s = count_r;
      if (bit_valid_s) begin
         state_nxt_s = next_tbl_s[{state_r, bit_val_s}];
      end else begin
         state_nxt_s = state_r;
      end
      if (detect_s) begin
         count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Output logic: falling-edge press decode, single-key filter, Mealy match.
   always_comb begin
      press_s     = prev_r & ~sync2_r;
      bit_valid_s = 1'b0;
      bit_val_s   = 1'b0;
      case (press_s)
         2'b01:   begin bit_valid_s = 1'b1; bit_val_s = 1'b0; end
         2'b10:   begin bit_valid_s = 1'b1; bit_val_s = 1'b1; end
         default: begin bit_valid_s = 1'b0; bit_val_s = 1'b0; end
      endcase
      detect_s = bit_valid_s & (state_r == 2'd3) & (bit_val_s == PATTERN[0]);
   end

`ifdef DET_REG_EN
   logic detect_r;

   // Registered copy of the match pulse for glitch-free LED drive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         detect_r <= 1'b0;
      end else begin
         detect_r <= detect_s;
      end
   end

   assign detect = detect_r;
`else
   assign detect = detect_s;
`endif

   assign bit_valid = bit_valid_s;
   assign bit_val   = bit_val_s;
   assign det_count = count_r;
   assign state     = {1'b0, state_r};

endmodule

// File: tb/tb_key_seq_mealy.sv
// Self-checking bench for key_seq_mealy: a history-based model (last bits
// entered, matched suffix computed from PATTERN) checked every cycle, plus
// literal expectations for each directed scenario. Two instances share the
// stimulus: CNT_W=8 and CNT_W=2 (counter wrap).
module tb_key_seq_mealy;

   localparam logic [3:0] PAT = 4'b1101;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic [1:0] debkey = 2'b11;

   logic       a_bit_valid, a_bit_val, a_detect;
   logic [7:0] a_det_count;
   logic [2:0] a_state;
   logic       b_bit_valid, b_bit_val, b_detect;
   logic [1:0] b_det_count;
   logic [2:0] b_state;

   int checks   = 0;
   int failures = 0;
   int bv_seen  = 0;
   int det_seen = 0;

   always #5 clk = ~clk;

   key_seq_mealy #(.PATTERN(PAT), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .debkey(debkey),
      .bit_valid(a_bit_valid), .bit_val(a_bit_val), .detect(a_detect),
      .det_count(a_det_count), .state(a_state));

   key_seq_mealy #(.PATTERN(PAT), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .debkey(debkey),
      .bit_valid(b_bit_valid), .bit_val(b_bit_val), .detect(b_detect),
      .det_count(b_det_count), .state(b_state));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // q0/q1/q2: key levels sampled at the last three edges (idle after reset).
   logic [1:0] m_q0, m_q1, m_q2;
   logic [3:0] m_hist;       // last bits entered, newest in bit 0
   int         m_nbits;      // bits entered since reset
   int         m_cnt;        // detections since reset
   logic       m_det_prev;   // combinational detect of the previous cycle

   // Matched prefix length: longest j<=3 where the last j bits equal the
   // first j bits of PAT.
   function automatic int exp_state(input logic [3:0] h, input int n);
      int res = 0;
      for (int j = 1; j <= 3; j++) begin
         if (j <= n && (((int'(h) ^ (int'(PAT) >> (4 - j))) & ((1 << j) - 1)) == 0))
            res = j;
      end
      return res;
   endfunction

   function automatic logic m_bv(input logic [1:0] p);
      return (p == 2'b01) || (p == 2'b10);
   endfunction

   logic [1:0] mu_p;
   logic       mu_bv, mu_dc;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q0 = 2'b11; m_q1 = 2'b11; m_q2 = 2'b11;
         m_hist = 4'b0; m_nbits = 0; m_cnt = 0; m_det_prev = 1'b0;
      end else begin
         mu_p  = m_q2 & ~m_q1;
         mu_bv = m_bv(mu_p);
         mu_dc = mu_bv && (m_nbits >= 3) && ({m_hist[2:0], mu_p[1]} == PAT);
         m_det_prev = mu_dc;
         if (mu_bv) begin
            if (mu_dc) m_cnt++;
            m_hist = {m_hist[2:0], mu_p[1]};
            m_nbits++;
         end
         m_q2 = m_q1; m_q1 = m_q0; m_q0 = debkey;
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [1:0] c_p;
   logic       c_bv, c_dc, c_det;
   int         c_st;

   always @(negedge clk) begin
      c_p  = m_q2 & ~m_q1;
      c_bv = reset && m_bv(c_p);
      c_dc = c_bv && (m_nbits >= 3) && ({m_hist[2:0], c_p[1]} == PAT);
`ifdef DET_REG_EN
      c_det = m_det_prev;
`else
      c_det = c_dc;
`endif
      c_st = exp_state(m_hist, m_nbits);
      check("a_bit_valid", a_bit_valid, c_bv);
      check("b_bit_valid", b_bit_valid, c_bv);
      if (c_bv) begin
         check("a_bit_val", a_bit_val, c_p[1]);
         check("b_bit_val", b_bit_val, c_p[1]);
      end
      check("a_detect", a_detect, c_det);
      check("b_detect", b_detect, c_det);
      check("a_state", a_state, c_st);
      check("b_state", b_state, c_st);
      check("a_det_count", a_det_count, m_cnt % 256);
      check("b_det_count", b_det_count, m_cnt % 4);
      if (a_bit_valid) bv_seen++;
      if (a_detect) det_seen++;
   end

   // ---------------- stimulus ----------------
   task automatic key(input logic b, input int hold);
      @(posedge clk); #2;
      debkey = b ? 2'b01 : 2'b10;
      repeat (hold) @(posedge clk);
      #2 debkey = 2'b11;
      repeat (5) @(posedge clk);
      #1;
   endtask

   // Enter n bits from bits, MSB (bit n-1) first.
   task automatic send(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) key(bits[i], 5);
   endtask

   task automatic do_reset();
      @(posedge clk); #2 reset = 1'b0;
      #20 reset = 1'b1;
      #1;
   endtask

   int bv0, det0;
   int st_exp [5] = '{1, 2, 2, 3, 1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; debkey = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", a_state, 0);
      check("rst_count", a_det_count, 0);
      check("rst_bit_valid", a_bit_valid, 0);
      check("rst_bit_val", a_bit_val, 0);
      check("rst_detect", a_detect, 0);
      #1 reset = 1'b1;

      // Idle after reset
      repeat (20) @(posedge clk);
      #1;
      check("idle_bv_seen", bv_seen, 0);
      check("idle_state", a_state, 0);
      check("idle_count", a_det_count, 0);

      // Basic 1101
      send(16'b1101, 4);
      check("basic_bv_seen", bv_seen, 4);
      check("basic_det_seen", det_seen, 1);
      check("basic_count", a_det_count, 1);
      check("basic_state", a_state, 1);

      // Overlap 1101101
      do_reset();
      det0 = det_seen;
      send(16'b1101, 4);
      check("ovl_det_after4", det_seen - det0, 1);
      send(16'b101, 3);
      check("ovl_det_after7", det_seen - det0, 2);
      check("ovl_count", a_det_count, 2);
      check("ovl_state", a_state, 1);

      // Fallback 11101: states 1,2,2,3 then match back to 1
      do_reset();
      det0 = det_seen;
      for (int i = 0; i < 5; i++) begin
         key((i == 3) ? 1'b0 : 1'b1, 5);
         check("fb_state", a_state, st_exp[i]);
         if (i == 3) check("fb_no_early_det", det_seen - det0, 0);
      end
      check("fb_det", det_seen - det0, 1);
      check("fb_count", a_det_count, 1);
      send(16'b1100, 4);
      check("fb_to_s0", a_state, 0);
      check("fb_to_s0_count", a_det_count, 1);

      // Both keys at once: ignored
      bv0 = bv_seen;
      @(posedge clk); #2 debkey = 2'b00;
      repeat (10) @(posedge clk);
      #2 debkey = 2'b11;
      repeat (5) @(posedge clk);
      #1;
      check("both_no_bv", bv_seen - bv0, 0);
      check("both_state", a_state, 0);

      // Long hold: single bit
      bv0 = bv_seen;
      key(1'b1, 100);
      check("hold_one_bv", bv_seen - bv0, 1);
      check("hold_state", a_state, 1);

      // Counter wrap on the CNT_W=2 instance
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         send(16'b1101, 4);
         check("wrap_a_count", a_det_count, k);
         check("wrap_b_count", b_det_count, k % 4);
      end

      // Reset mid-sequence
      do_reset();
      det0 = det_seen;
      send(16'b110, 3);
      check("mid_pre_state", a_state, 3);
      @(posedge clk); #2 reset = 1'b0;
      #1;
      check("mid_a_state", a_state, 0);
      check("mid_b_state", b_state, 0);
      #20 reset = 1'b1;
      key(1'b1, 5);
      check("mid_after_state", a_state, 1);
      check("mid_no_det", det_seen - det0, 0);
      check("mid_count", a_det_count, 0);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
